// File: rtl/icache_pkg.sv
// Shared types and helpers for the N-way instruction cache: controller
// state encoding, address-field width helpers and the tree pseudo-LRU
// update/victim functions (trees of up to 8 ways, 7 node bits).
package icache_pkg;

  typedef enum logic [2:0] {
    S_SWEEP  = 3'd0,
    S_IDLE   = 3'd1,
    S_LOOKUP = 3'd2,
    S_REFILL = 3'd3,
    S_FILL   = 3'd4,
    S_INV    = 3'd5
  } state_e;

  function automatic int off_w(input int line_words);
    return 2 + $clog2(line_words);
  endfunction

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets, input int line_words);
    return 32 - idx_w(sets) - off_w(line_words);
  endfunction

  // Tree nodes are stored heap-style: node n lives in bit n-1, children of
  // node n are 2n (lower ways) and 2n+1 (upper ways). A bit of 0 points to
  // the lower half. Accessing a way flips every node on its path away from it.
  function automatic logic [6:0] plru_update(input logic [6:0] tree,
                                             input logic [2:0] way,
                                             input int         ways);
    logic [6:0] t;
    logic [3:0] node;
    logic [2:0] wsh;
    int         lvls;
    t    = tree;
    node = 4'd1;
    lvls = $clog2(ways);
    for (int l = 0; l < 3; l++) begin
      if (l < lvls) begin
        wsh                  = way >> (lvls - 1 - l);
        t[node[2:0] - 3'd1]  = ~wsh[0];
        node                 = {node[2:0], wsh[0]};
      end
    end
    return t;
  endfunction

  // Follow the tree pointers from the root down to a leaf.
  function automatic logic [2:0] plru_victim(input logic [6:0] tree,
                                             input int         ways);
    logic [3:0] node;
    logic [3:0] leaf;
    int         lvls;
    node = 4'd1;
    lvls = $clog2(ways);
    for (int l = 0; l < 3; l++) begin
      if (l < lvls) begin
        node = {node[2:0], tree[node[2:0] - 3'd1]};
      end
    end
    leaf = node - 4'(ways);
    return leaf[2:0];
  endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Bus bundle of the instruction cache: CPU fetch/invalidate side and the
// AXI line-read request/grant side. "slave" is the cache's view, "master"
// is the view of the CPU plus memory environment driving it.
interface icache_nway_if
  import icache_pkg::*;
#(
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
);
  logic                        rd_req;
  logic [31:0]                 addr;
  logic                        rd_valid;
  logic [31:0]                 rd_data;
  logic                        busy;
  logic                        inv_req;
  logic [idx_w(SETS)-1:0]      inv_index;
  logic                        inv_done;
  logic                        axi_rd_req;
  logic [31:0]                 axi_addr;
  logic                        axi_gnt;
  logic [LINE_WORDS*32-1:0]    axi_data;

  modport slave (
    input  rd_req, addr, inv_req, inv_index, axi_gnt, axi_data,
    output rd_valid, rd_data, busy, inv_done, axi_rd_req, axi_addr
  );

  modport master (
    output rd_req, addr, inv_req, inv_index, axi_gnt, axi_data,
    input  rd_valid, rd_data, busy, inv_done, axi_rd_req, axi_addr
  );
endinterface

// File: rtl/icache_way_ram.sv
// Single-port RAM with synchronous read; one instance holds either the
// tag+valid column or the line column of one cache way.
module icache_way_ram #(
  parameter int DEPTH = 128,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port and registered read (old data on a same-cycle write).
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    rdata_o <= mem_q[addr_i];
  end
endmodule

// File: rtl/icache_nway.sv
// N-way set-associative read-only instruction cache.
// Hit: rd_valid the cycle after the request is accepted. Miss: one line is
// refilled over the AXI request/grant interface, written into the victim
// way and the requested word forwarded. A reset sweep clears all valid bits.
// Build option ICACHE_PLRU_EN: tree pseudo-LRU replacement; otherwise a
// per-set round-robin counter advanced on every fill.
module icache_nway
  import icache_pkg::*;
#(
  parameter int WAYS       = 4,
  parameter int SETS       = 128,
  parameter int LINE_WORDS = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  icache_nway_if.slave bus
);
  localparam int OFF_W  = off_w(LINE_WORDS);
  localparam int IDX_W  = idx_w(SETS);
  localparam int TAG_W  = tag_w(SETS, LINE_WORDS);
  localparam int WAY_W  = $clog2(WAYS);
  localparam int WRD_W  = $clog2(LINE_WORDS);
  localparam int LINE_W = LINE_WORDS * 32;

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    sweep_q, sweep_d;
  logic [IDX_W-1:0]    inv_idx_q, inv_idx_d;
  logic [WAY_W-1:0]    victim_q, victim_d;
  logic [31:0]         addr_q, addr_d;
  logic [LINE_W-1:0]   line_q, line_d;

  logic [IDX_W-1:0]    ram_addr;
  logic [WAYS-1:0]     tag_we;
  logic [WAYS-1:0]     data_we;
  logic [TAG_W:0]      tag_wdata;
  logic [TAG_W:0]      tag_rd  [WAYS];
  logic [LINE_W-1:0]   data_rd [WAYS];

  logic [IDX_W-1:0]    cur_idx;
  logic [TAG_W-1:0]    cur_tag;
  logic [WRD_W-1:0]    cur_wrd;

  logic                hit_any;
  logic [WAY_W-1:0]    hit_way;
  logic                inv_any;
  logic [WAY_W-1:0]    inv_way;
  logic [WAY_W-1:0]    pol_way;
  logic [WAY_W-1:0]    acc_way;
  logic                repl_upd;

  logic [LINE_W-1:0]   hit_line;
  logic [31:0]         hit_word;
  logic [31:0]         fill_word;

  logic                rd_valid;
  logic [31:0]         rd_data;
  logic                busy;
  logic                inv_done;
  logic                axi_rd_req;

  assign cur_idx   = addr_q[OFF_W +: IDX_W];
  assign cur_tag   = addr_q[31 -: TAG_W];
  assign cur_wrd   = addr_q[2 +: WRD_W];
  assign hit_line  = data_rd[hit_way];
  assign hit_word  = hit_line[{cur_wrd, 5'd0} +: 32];
  assign fill_word = line_q[{cur_wrd, 5'd0} +: 32];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way_ram #(.DEPTH(SETS), .WIDTH(TAG_W + 1)) u_tag (
      .clk     (clk),
      .we_i    (tag_we[w]),
      .addr_i  (ram_addr),
      .wdata_i (tag_wdata),
      .rdata_o (tag_rd[w])
    );
    icache_way_ram #(.DEPTH(SETS), .WIDTH(LINE_W)) u_data (
      .clk     (clk),
      .we_i    (data_we[w]),
      .addr_i  (ram_addr),
      .wdata_i (line_q),
      .rdata_o (data_rd[w])
    );
  end

  // Tag match (lowest hitting way wins) and lowest invalid way.
  always_comb begin
    hit_any = 1'b0;
    hit_way = '0;
    inv_any = 1'b0;
    inv_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (tag_rd[w][TAG_W] && (tag_rd[w][TAG_W-1:0] == cur_tag)) begin
        hit_any = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!tag_rd[w][TAG_W]) begin
        inv_any = 1'b1;
        inv_way = WAY_W'(w);
      end
    end
  end

`ifdef ICACHE_PLRU_EN
  logic [WAYS-2:0] plru_q [SETS];
  logic [6:0]      tree_cur;
  logic [6:0]      tree_upd;
  logic [2:0]      tree_vict;
  logic            unused_bits;

  // Tree lookup for the set under access: updated tree and pointed-to way.
  always_comb begin
    tree_cur  = 7'(plru_q[cur_idx]);
    tree_upd  = plru_update(tree_cur, 3'(acc_way), WAYS);
    tree_vict = plru_victim(tree_cur, WAYS);
  end

  assign pol_way     = tree_vict[WAY_W-1:0];
  assign unused_bits = ^{tree_upd, tree_vict};

  // Point the set's tree away from the way just hit or filled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        plru_q[s] <= '0;
      end
    end else if (repl_upd) begin
      plru_q[cur_idx] <= tree_upd[WAYS-2:0];
    end
  end
`else
  logic [WAY_W-1:0] rr_q [SETS];
  logic             unused_bits;

  assign pol_way     = rr_q[cur_idx];
  assign unused_bits = ^acc_way;

  // Round-robin pointer of the set advances on fills only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < SETS; s++) begin
        rr_q[s] <= '0;
      end
    end else if (repl_upd && (state_q == S_FILL)) begin
      rr_q[cur_idx] <= rr_q[cur_idx] + WAY_W'(1);
    end
  end
`endif

  // Controller next state, RAM port control and handshake outputs.
  always_comb begin
    state_d    = state_q;
    sweep_d    = sweep_q;
    inv_idx_d  = inv_idx_q;
    victim_d   = victim_q;
    addr_d     = addr_q;
    line_d     = line_q;
    ram_addr   = cur_idx;
    tag_we     = '0;
    data_we    = '0;
    tag_wdata  = '0;
    rd_valid   = 1'b0;
    rd_data    = '0;
    busy       = 1'b0;
    inv_done   = 1'b0;
    axi_rd_req = 1'b0;
    repl_upd   = 1'b0;
    acc_way    = hit_way;
    case (state_q)
      S_SWEEP: begin
        busy     = 1'b1;
        ram_addr = sweep_q;
        tag_we   = '1;
        sweep_d  = sweep_q + IDX_W'(1);
        if (&sweep_q) begin
          state_d = S_IDLE;
        end
      end
      S_IDLE: begin
        ram_addr = bus.addr[OFF_W +: IDX_W];
        if (bus.inv_req) begin
          inv_idx_d = bus.inv_index;
          state_d   = S_INV;
        end else if (bus.rd_req) begin
          addr_d  = bus.addr;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit_any) begin
          rd_valid = 1'b1;
          rd_data  = hit_word;
          repl_upd = 1'b1;
          // CPU already presents its next address: keep streaming hits.
          if (bus.rd_req && (bus.addr != addr_q)) begin
            ram_addr = bus.addr[OFF_W +: IDX_W];
            addr_d   = bus.addr;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          victim_d = inv_any ? inv_way : pol_way;
          state_d  = S_REFILL;
        end
      end
      S_REFILL: begin
        busy       = 1'b1;
        axi_rd_req = 1'b1;
        if (bus.axi_gnt) begin
          line_d  = bus.axi_data;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        busy              = 1'b1;
        tag_we[victim_q]  = 1'b1;
        data_we[victim_q] = 1'b1;
        tag_wdata         = {1'b1, cur_tag};
        rd_valid          = 1'b1;
        rd_data           = fill_word;
        repl_upd          = 1'b1;
        acc_way           = victim_q;
        state_d           = S_IDLE;
      end
      S_INV: begin
        busy     = 1'b1;
        ram_addr = inv_idx_q;
        tag_we   = '1;
        inv_done = 1'b1;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_SWEEP;
      end
    endcase
  end

  // Control state: reset restarts the valid-bit sweep from set 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_SWEEP;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      sweep_q <= sweep_d;
    end
  end

  // Datapath holding registers; only meaningful once the FSM loads them.
  always_ff @(posedge clk) begin
    addr_q    <= addr_d;
    line_q    <= line_d;
    inv_idx_q <= inv_idx_d;
    victim_q  <= victim_d;
  end

  assign bus.rd_valid   = rd_valid;
  assign bus.rd_data    = rd_data;
  assign bus.busy       = busy;
  assign bus.inv_done   = inv_done;
  assign bus.axi_rd_req = axi_rd_req;
  assign bus.axi_addr   = axi_rd_req ? {addr_q[31:OFF_W], OFF_W'(0)} : 32'd0;

endmodule

// File: tb/tb_icache_nway.sv
// Directed bench for icache_nway (4 ways, 128 sets, 8-word lines).
// Refill lines use word w = (line_address >> 4) + w, so line 0x1000 holds
// 0x100..0x107.
module tb_icache_nway;
  localparam int WAYS = 4;
  localparam int SETS = 128;
  localparam int LW   = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  icache_nway_if #(.SETS(SETS), .LINE_WORDS(LW)) bus ();

  icache_nway #(.WAYS(WAYS), .SETS(SETS), .LINE_WORDS(LW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [LW*32-1:0] mk_line(input logic [31:0] la);
    logic [LW*32-1:0] l;
    for (int w = 0; w < LW; w++) begin
      l[w*32 +: 32] = (la >> 4) + 32'(w);
    end
    return l;
  endfunction

  // Issue one fetch from IDLE and serve a refill if one is requested.
  task automatic fetch(input logic [31:0] a, output logic hit, output logic ok,
                       output logic [31:0] data, output logic [31:0] raddr);
    int n;
    hit = 1'b0; ok = 1'b0; data = '0; raddr = '0;
    bus.rd_req = 1'b1;
    bus.addr   = a;
    @(posedge clk); #1;
    if (bus.rd_valid) begin
      hit = 1'b1; ok = 1'b1; data = bus.rd_data;
    end else begin
      n = 0;
      while (!bus.axi_rd_req && n < 10) begin
        @(posedge clk); #1;
        n++;
      end
      if (bus.axi_rd_req) begin
        raddr        = bus.axi_addr;
        bus.axi_data = mk_line(bus.axi_addr);
        bus.axi_gnt  = 1'b1;
        @(posedge clk); #1;
        bus.axi_gnt = 1'b0;
        if (bus.rd_valid) begin
          ok = 1'b1; data = bus.rd_data;
        end
      end
    end
    bus.rd_req = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic count_sweep(output int n);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (bus.busy && n < 300);
  endtask

  task automatic test_reset();
    logic hit, ok; logic [31:0] d, ra; int n;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL reset_busy: got %b want 1", bus.busy); end
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL reset_rd_valid: got %b want 0", bus.rd_valid); end
    total++; if (bus.rd_data !== 32'd0) begin bad++; $display("FAIL reset_rd_data: got %h want 0", bus.rd_data); end
    total++; if (bus.inv_done !== 1'b0) begin bad++; $display("FAIL reset_inv_done: got %b want 0", bus.inv_done); end
    total++; if (bus.axi_rd_req !== 1'b0) begin bad++; $display("FAIL reset_axi_req: got %b want 0", bus.axi_rd_req); end
    total++; if (bus.axi_addr !== 32'd0) begin bad++; $display("FAIL reset_axi_addr: got %h want 0", bus.axi_addr); end
    @(negedge clk);
    rst_n = 1'b1;
    count_sweep(n);
    total++; if (n != 128) begin bad++; $display("FAIL sweep_len: got %0d want 128", n); end
    fetch(32'h0000_0040, hit, ok, d, ra);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL first_fetch_miss: got hit=%b want 0", hit); end
    total++; if (ok !== 1'b1 || d !== 32'h4) begin bad++; $display("FAIL first_fetch_data: got ok=%b %h want 1 00000004", ok, d); end
  endtask

  task automatic test_cold_miss();
    logic hit, ok; logic [31:0] d, ra;
    fetch(32'h0000_1004, hit, ok, d, ra);
    total++; if (hit !== 1'b0) begin bad++; $display("FAIL cold_miss: got hit=%b want 0", hit); end
    total++; if (ra !== 32'h0000_1000) begin bad++; $display("FAIL cold_axi_addr: got %h want 00001000", ra); end
    total++; if (ok !== 1'b1 || d !== 32'h101) begin bad++; $display("FAIL cold_data: got ok=%b %h want 1 00000101", ok, d); end
    fetch(32'h0000_1008, hit, ok, d, ra);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL warm_hit: got hit=%b want 1", hit); end
    total++; if (d !== 32'h102) begin bad++; $display("FAIL warm_data: got %h want 00000102", d); end
  endtask

  task automatic test_back_to_back();
    bus.rd_req = 1'b1;
    bus.addr   = 32'h0000_1000;
    @(posedge clk); #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h100) begin bad++; $display("FAIL b2b_0: got v=%b %h want 1 00000100", bus.rd_valid, bus.rd_data); end
    bus.addr = 32'h0000_100C;
    @(posedge clk); #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h103) begin bad++; $display("FAIL b2b_1: got v=%b %h want 1 00000103", bus.rd_valid, bus.rd_data); end
    total++; if (bus.axi_rd_req !== 1'b0) begin bad++; $display("FAIL b2b_no_axi: got %b want 0", bus.axi_rd_req); end
    bus.addr = 32'h0000_101C;
    @(posedge clk); #1;
    total++; if (bus.rd_valid !== 1'b1 || bus.rd_data !== 32'h107) begin bad++; $display("FAIL b2b_2: got v=%b %h want 1 00000107", bus.rd_valid, bus.rd_data); end
    bus.rd_req = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.rd_valid !== 1'b0) begin bad++; $display("FAIL b2b_end: got v=%b want 0", bus.rd_valid); end
  endtask

  task automatic test_fill_ways();
    logic hit, ok; logic [31:0] d, ra;
    logic [31:0] la [4] = '{32'h1000, 32'h2000, 32'h3000, 32'h4000};
    logic [31:0] ld [4] = '{32'h100, 32'h200, 32'h300, 32'h400};
    for (int i = 1; i < 4; i++) begin
      fetch(la[i], hit, ok, d, ra);
      total++; if (hit !== 1'b0 || ra !== la[i]) begin bad++; $display("FAIL fill_miss_%0d: got hit=%b axi=%h want 0 %h", i, hit, ra, la[i]); end
      total++; if (ok !== 1'b1 || d !== ld[i]) begin bad++; $display("FAIL fill_data_%0d: got ok=%b %h want 1 %h", i, ok, d, ld[i]); end
    end
    for (int i = 0; i < 4; i++) begin
      fetch(la[i], hit, ok, d, ra);
      total++; if (hit !== 1'b1 || d !== ld[i]) begin bad++; $display("FAIL fill_hit_%0d: got hit=%b %h want 1 %h", i, hit, d, ld[i]); end
    end
  endtask

  task automatic test_replacement();
    logic hit, ok; logic [31:0] d, ra; logic exp_hit;
`ifdef ICACHE_PLRU_EN
    exp_hit = 1'b1;
`else
    exp_hit = 1'b0;
`endif
    fetch(32'h0000_1000, hit, ok, d, ra);
    total++; if (hit !== 1'b1) begin bad++; $display("FAIL repl_touch: got hit=%b want 1", hit); end
    fetch(32'h0000_5000, hit, ok, d, ra);
    total++; if (hit !== 1'b0 || d !== 32'h500) begin bad++; $display("FAIL repl_new: got hit=%b %h want 0 00000500", hit, d); end
    fetch(32'h0000_1000, hit, ok, d, ra);
    total++; if (hit !== exp_hit) begin bad++; $display("FAIL repl_victim: got hit=%b want %b", hit, exp_hit); end
    total++; if (ok !== 1'b1 || d !== 32'h100) begin bad++; $display("FAIL repl_data: got ok=%b %h want 1 00000100", ok, d); end
  endtask

  task automatic test_invalidate();
    logic hit, ok; logic [31:0] d, ra;
    fetch(32'h0000_4000, hit, ok, d, ra);
    total++; if (hit !== 1'b1 || d !== 32'h400) begin bad++; $display("FAIL inv_pre_hit: got hit=%b %h want 1 00000400", hit, d); end
    bus.inv_req   = 1'b1;
    bus.inv_index = '0;
    @(posedge clk); #1;
    total++; if (bus.inv_done !== 1'b1 || bus.busy !== 1'b1) begin bad++; $display("FAIL inv_done: got done=%b busy=%b want 1 1", bus.inv_done, bus.busy); end
    bus.inv_req = 1'b0;
    @(posedge clk); #1;
    total++; if (bus.inv_done !== 1'b0) begin bad++; $display("FAIL inv_pulse: got %b want 0", bus.inv_done); end
    fetch(32'h0000_4000, hit, ok, d, ra);
    total++; if (hit !== 1'b0 || d !== 32'h400) begin bad++; $display("FAIL inv_miss: got hit=%b %h want 0 00000400", hit, d); end
    fetch(32'h0000_0040, hit, ok, d, ra);
    total++; if (hit !== 1'b1 || d !== 32'h4) begin bad++; $display("FAIL inv_other_set: got hit=%b %h want 1 00000004", hit, d); end
  endtask

  task automatic test_reset_refill();
    logic hit, ok; logic [31:0] d, ra; int n;
    bus.rd_req = 1'b1;
    bus.addr   = 32'h0000_6000;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.axi_rd_req && n < 10);
    total++; if (bus.axi_rd_req !== 1'b1) begin bad++; $display("FAIL rr_refill_req: got %b want 1", bus.axi_rd_req); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.axi_rd_req !== 1'b0) begin bad++; $display("FAIL rr_async_drop: got %b want 0", bus.axi_rd_req); end
    total++; if (bus.busy !== 1'b1 || bus.rd_valid !== 1'b0) begin bad++; $display("FAIL rr_state: got busy=%b v=%b want 1 0", bus.busy, bus.rd_valid); end
    bus.rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    count_sweep(n);
    total++; if (n != 128) begin bad++; $display("FAIL rr_sweep_len: got %0d want 128", n); end
    fetch(32'h0000_1000, hit, ok, d, ra);
    total++; if (hit !== 1'b0 || d !== 32'h100) begin bad++; $display("FAIL rr_post_miss: got hit=%b %h want 0 00000100", hit, d); end
    fetch(32'h0000_6000, hit, ok, d, ra);
    total++; if (hit !== 1'b0 || ra !== 32'h6000 || d !== 32'h600) begin bad++; $display("FAIL rr_refetch: got hit=%b axi=%h %h want 0 00006000 00000600", hit, ra, d); end
  endtask

  initial begin
    bus.rd_req    = 1'b0;
    bus.addr      = '0;
    bus.inv_req   = 1'b0;
    bus.inv_index = '0;
    bus.axi_gnt   = 1'b0;
    bus.axi_data  = '0;
    test_reset();
    test_cold_miss();
    test_back_to_back();
    test_fill_ways();
    test_replacement();
    test_invalidate();
    test_reset_refill();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/icache_nway.md
# icache_nway

Parametrised N-way set-associative, read-only instruction cache; the next generation of the IF-stage icache. Looks up a 32-bit fetch address, returns the instruction word on a hit, and on a miss refills one full line over the existing AXI line-read request/grant interface. Adds configurable geometry, a registered valid/stall handshake, first-invalid-way victim choice, a selectable replacement policy, and a per-set invalidate port for CACHE instructions.

## Interface
- WAYS, 4: associativity; power of two, 2..8
- SETS, 128: sets per way; power of two, 16..512
- LINE_WORDS, 8: 32-bit words per line; power of two, 4..16
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  fetch request; CPU holds addr stable until rd_valid
- addr  in  32  fetch byte address, word aligned
- rd_valid  out  1  one-cycle pulse: rd_data valid for the held addr
- rd_data  out  32  instruction word
- busy  out  1  high while reset sweep, refill or invalidate is in progress
- inv_req  in  1  invalidate all ways of set inv_index
- inv_index  in  log2(SETS)  set to invalidate
- inv_done  out  1  one-cycle pulse when invalidate is complete
- axi_rd_req  out  1  line read request, held until axi_gnt
- axi_addr  out  32  line-aligned refill address
- axi_gnt  in  1  refill data valid this cycle
- axi_data  in  LINE_WORDS x 32  refill line, word 0 at lowest address

## Operation
- Address split: offset = 2+log2(LINE_WORDS) bits, index = log2(SETS) bits, TAG_W = 32 - index - offset bits.
- Storage per way: tag+valid RAM (TAG_W+1 bits x SETS) and data RAM (LINE_WORDS*32 bits x SETS), synchronous read, one write port.
- States: SWEEP, IDLE, LOOKUP, REFILL, FILL, INV.
- SWEEP: entered on reset; writes valid=0 to set 0..SETS-1, one set per cycle, in all ways. Then IDLE. busy=1 throughout; rd_req and inv_req are ignored.
- IDLE: inv_req has priority over rd_req. inv_req -> INV. rd_req -> RAMs read at addr index -> LOOKUP.
- LOOKUP: compares the registered tag against all ways.
  - Hit (exactly one way): rd_valid=1 with the selected word; replacement state updated. If rd_req is still high with a new addr (CPU advanced), the RAMs are re-read and the state stays LOOKUP, giving back-to-back hits; otherwise -> IDLE.
  - Miss: victim chosen and latched -> REFILL.
- REFILL: axi_rd_req=1, axi_addr = {addr[31:offset], 0}. On axi_gnt the line is latched -> FILL.
- FILL: writes tag, valid=1 and the line into the victim way; rd_valid=1 with the word forwarded from the latched line; replacement state updated -> IDLE.
- INV: clears valid in all ways of inv_index; inv_done=1 -> IDLE.
- Victim: lowest-numbered invalid way; if all ways are valid, the policy way (see Configuration).
- Multiple ways hitting (corrupt state) selects the lowest way; no assertion in RTL.
- Reset mid-operation: all state is dropped, any pending refill is abandoned (axi_rd_req drops asynchronously), and SWEEP restarts from set 0.

## Timing
- Reset values: rd_valid=0, rd_data=0, busy=1, inv_done=0, axi_rd_req=0, axi_addr=0; replacement state all zero.
- Hit latency: request accepted in cycle N (IDLE), rd_valid in N+1. Sustained hits give one word per cycle.
- Miss: lookup at N+1, axi_rd_req from N+2, axi_gnt at G, rd_valid at G+1. The line is readable by a lookup from G+2.
- SWEEP lasts SETS cycles after rst_n deasserts; IDLE is reached at cycle SETS.
- inv_req accepted in IDLE at cycle N: inv_done at N+1. A lookup of that set started at N+2 or later misses.
- rd_req or inv_req arriving while busy is held off, not dropped: the requester keeps it asserted.

## Configuration
- ICACHE_PLRU_EN defined: tree pseudo-LRU, WAYS-1 bits per set. Tree bits are updated to point away from the accessed way on every hit and fill. Victim = way the tree points to.
- ICACHE_PLRU_EN undefined: per-set round-robin counter, log2(WAYS) bits. It increments on fill only, and victim = counter value. Hits do not change it.

## Structure
- Package icache_pkg holds: the state enum, and functions for index/offset/tag widths and for PLRU tree update/victim selection.
- Sub-module icache_way_ram: a synchronous-read single-port RAM parametrised by depth and width. It is instantiated twice per way, once for tag+valid and once for the line.

## Test plan
- Reset sweep: release rst_n -> busy=1 for exactly 128 cycles; every first fetch then misses (axi_rd_req=1).
- Cold miss then hit: fetch 0x0000_1004 -> axi_addr=0x0000_1000; gnt with line 0x100..0x107 -> rd_valid with 0x101. Next fetch 0x0000_1008 -> rd_valid next cycle with 0x102, no axi_rd_req.
- Fill ways: fetch 0x1000, 0x2000, 0x3000, 0x4000 (same set 0), each a miss, filling ways 0..3 in order. All four then hit.
- Replacement: after the above, re-fetch 0x1000 and then miss on 0x5000. With PLRU_EN the victim is not way 0 and 0x1000 still hits. Without it the victim is way 0 and 0x1000 misses.
- Invalidate: inv_req with inv_index=0 while idle -> inv_done next cycle; fetch 0x2000 then misses.
- Async reset during REFILL: drop rst_n with axi_rd_req=1 -> axi_rd_req=0 immediately, no rd_valid, sweep restarts.
